// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: icodes, status codes, FSM states and the
// payload records passed between the splitter and the F/D pipeline register.
package y86_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned INST_W     = 80;
  localparam int unsigned INST_BYTES = 10;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_WAIT_RET = 2'd1,
    S_HALTED   = 2'd2
  } fetch_state_e;

  // Contents of the F/D pipeline register.
  typedef struct packed {
    logic            valid;
    logic [2:0]      stat;
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [XLEN-1:0] valc;
    logic [XLEN-1:0] valp;
  } fd_rec_t;

  // Everything the splitter derives from one fetch window.
  typedef struct packed {
    logic [2:0]      stat;
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [XLEN-1:0] valc;
    logic [XLEN-1:0] valp;
    logic [XLEN-1:0] pred_pc;
  } split_t;

  function automatic fd_rec_t bubble_rec();
    fd_rec_t r;
    r.valid = 1'b0;
    r.stat  = SAOK;
    r.icode = INOP;
    r.ifun  = 4'h0;
    r.ra    = RNONE;
    r.rb    = RNONE;
    r.valc  = '0;
    r.valp  = '0;
    return r;
  endfunction

  // Byte k of the fetch window; byte 0 sits in the most significant bits.
  function automatic logic [7:0] inst_byte(input logic [INST_W-1:0] inst,
                                           input int unsigned k);
    return inst[INST_W-1-8*k -: 8];
  endfunction

endpackage

// File: rtl/y86_inst_split.sv
// Combinational instruction splitter: field extraction, length, valC,
// validity, valP, fetch status and predicted next PC.
module y86_inst_split
  import y86_pkg::*;
#(
  parameter logic [XLEN-1:0] IMEM_LIMIT = 64'hFFF
) (
  input  logic [XLEN-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output split_t            split_c_o
);

  logic [7:0]      b [INST_BYTES];
  logic [3:0]      icode;
  logic [3:0]      ifun;
  logic            need_reg;
  logic            invalid;
  logic [3:0]      len;
  logic [XLEN-1:0] valc;
  logic [XLEN-1:0] valp;
  logic [XLEN:0]   last_addr;
  logic [2:0]      stat;

  always_comb begin
    for (int unsigned k = 0; k < INST_BYTES; k++) begin
      b[k] = inst_byte(inst_i, k);
    end
  end

  assign icode = b[0][7:4];
  assign ifun  = b[0][3:0];

  // Per-icode length, constant word placement and legal function codes.
  always_comb begin
    need_reg = 1'b0;
    invalid  = 1'b0;
    len      = 4'd1;
    valc     = '0;
    case (icode)
      IHALT, INOP, IRET: begin
        invalid = (ifun != 4'h0);
      end
      IRRMOVQ: begin
        need_reg = 1'b1;
        len      = 4'd2;
        invalid  = (ifun > 4'h6);
      end
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        need_reg = 1'b1;
        len      = 4'd10;
        valc     = {b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2]};
        invalid  = (ifun != 4'h0);
      end
      IOPQ: begin
        need_reg = 1'b1;
        len      = 4'd2;
        invalid  = (ifun > 4'h3);
      end
      IJXX: begin
        len     = 4'd9;
        valc    = {b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1]};
        invalid = (ifun > 4'h6);
      end
      ICALL: begin
        len     = 4'd9;
        valc    = {b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1]};
        invalid = (ifun != 4'h0);
      end
      IPUSHQ, IPOPQ: begin
        need_reg = 1'b1;
        len      = 4'd2;
        invalid  = (ifun != 4'h0);
      end
      default: begin
        invalid = 1'b1;
      end
    endcase
  end

  // Carry out of the last-byte address means the instruction wraps memory.
  assign last_addr = {1'b0, pc_i} + (XLEN+1)'(len) - (XLEN+1)'(1);
  assign valp      = pc_i + XLEN'(len);

  always_comb begin
    stat = SAOK;
    if (last_addr[XLEN] || (last_addr[XLEN-1:0] > IMEM_LIMIT)) begin
      stat = SADR;
    end else if (invalid) begin
      stat = SINS;
    end else if (icode == IHALT) begin
      stat = SHLT;
    end
  end

  always_comb begin
    split_c_o.stat    = stat;
    split_c_o.icode   = icode;
    split_c_o.ifun    = ifun;
    split_c_o.ra      = (need_reg && (icode != IIRMOVQ)) ? b[1][7:4] : RNONE;
    split_c_o.rb      = need_reg ? b[1][3:0] : RNONE;
    split_c_o.valc    = valc;
    split_c_o.valp    = valp;
    split_c_o.pred_pc = ((icode == IJXX) || (icode == ICALL)) ? valc : valp;
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC register, run/wait-for-ret/halted control and the
// F/D pipeline register fed by the instruction splitter.
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] IMEM_LIMIT = 64'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] pc,
  input  logic [79:0] inst,
  input  logic        stall,
  input  logic        bubble,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        d_valid,
  output logic [2:0]  d_stat,
  output logic [3:0]  d_icode,
  output logic [3:0]  d_ifun,
  output logic [3:0]  d_ra,
  output logic [3:0]  d_rb,
  output logic [63:0] d_valc,
  output logic [63:0] d_valp
);

  logic [XLEN-1:0] pc_q;
  fetch_state_e    state_q;
  fd_rec_t         fd_q;
  fd_rec_t         fd_d;
  split_t          split;

  y86_inst_split #(
    .IMEM_LIMIT (IMEM_LIMIT)
  ) u_split (
    .pc_i      (pc_q),
    .inst_i    (inst),
    .split_c_o (split)
  );

  always_comb begin
    fd_d       = bubble_rec();
    fd_d.valid = 1'b1;
    fd_d.stat  = split.stat;
    fd_d.icode = split.icode;
    fd_d.ifun  = split.ifun;
    fd_d.ra    = split.ra;
    fd_d.rb    = split.rb;
    fd_d.valc  = split.valc;
    fd_d.valp  = split.valp;
  end

  // Priority: reset, then redirect, then stall, then normal per-state advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= S_RUN;
      fd_q    <= bubble_rec();
    end else if (redirect_valid) begin
      pc_q    <= redirect_pc;
      state_q <= S_RUN;
      fd_q    <= bubble_rec();
    end else if (!stall) begin
      case (state_q)
        S_RUN: begin
          fd_q <= bubble ? bubble_rec() : fd_d;
          if (split.stat != SAOK) begin
            state_q <= S_HALTED;
          end else if (split.icode == IRET) begin
            state_q <= S_WAIT_RET;
          end else begin
            pc_q <= split.pred_pc;
          end
        end
        default: begin
          fd_q <= bubble_rec();
        end
      endcase
    end
  end

  assign pc      = pc_q;
  assign d_valid = fd_q.valid;
  assign d_stat  = fd_q.stat;
  assign d_icode = fd_q.icode;
  assign d_ifun  = fd_q.ifun;
  assign d_ra    = fd_q.ra;
  assign d_rb    = fd_q.rb;
  assign d_valc  = fd_q.valc;
  assign d_valp  = fd_q.valp;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Parameter IMEM_LIMIT, default 64'hFFF, highest valid instruction byte address.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 pc  output  64  fetch address driven to instruction memory; equals internal PC register.
REQ-006 inst  input  80  instruction bytes for pc; byte k = inst[79-8k -: 8], valid before the next posedge.
REQ-007 stall  input  1  hold PC and D register.
REQ-008 bubble  input  1  load NOP bubble into D register.
REQ-009 redirect_valid  input  1  later-stage PC correction (mispredict or ret).
REQ-010 redirect_pc  input  64  corrected PC.
REQ-011 d_valid, d_stat[2:0], d_icode[3:0], d_ifun[3:0], d_ra[3:0], d_rb[3:0], d_valc[63:0], d_valp[63:0]  outputs  registered F/D fields.

Function
REQ-012 Byte 0 SHALL split as icode=[7:4], ifun=[3:0]; register byte = byte 1 for icodes 2,3,4,5,6,A,B.
REQ-013 Length SHALL be 1 for icodes 0,1,9; 2 for 2,6,A,B; 9 for 7,8; 10 for 3,4,5.
REQ-014 valC SHALL be little-endian bytes 2..9 for icodes 3,4,5 and bytes 1..8 for 7,8; else 0.
REQ-015 rA/rB SHALL be 4'hF when no register byte; irmovq rA forced 4'hF.
REQ-016 valP SHALL be pc + length, modulo 2^64.
REQ-017 Instruction invalid if icode > B, or ifun nonzero for icodes 0,1,3,4,5,8,9,A,B, or ifun > 6 for 2/7, or ifun > 3 for 6.
REQ-018 Status priority: ADR (3) if pc+length-1 > IMEM_LIMIT or sum overflows; else INS (4) if invalid; else HLT (2) if icode 0; else AOK (1).
REQ-019 Predicted next PC SHALL be valC for icode 7 and 8, else valP.
REQ-020 FSM states RUN, WAIT_RET, HALTED.
REQ-021 RUN, no stall: PC <= predicted PC; D register <= decoded fields, d_valid=1; one instruction per cycle.
REQ-022 RUN fetching icode 9: latch it, hold PC, go WAIT_RET.
REQ-023 RUN fetching status != AOK: latch it with that status, hold PC, go HALTED.
REQ-024 WAIT_RET/HALTED, no redirect: PC held; D register loads bubble each cycle.
REQ-025 redirect_valid in any state: PC <= redirect_pc, state <= RUN, D register <= bubble; overrides stall and bubble.
REQ-026 stall (no redirect): PC, state, D register unchanged.
REQ-027 bubble without stall or redirect: D register <= bubble; PC and state advance as REQ-021..023.
REQ-028 stall and bubble together without redirect: stall wins.
REQ-029 Bubble = d_valid 0, icode 1, ifun 0, ra/rb F, valc/valp 0, stat AOK.
REQ-030 Fetch latency: D register holds instruction at pc exactly one posedge after pc presented.

Reset
REQ-031 rst_n low at posedge: pc=RESET_PC, state RUN, D register = bubble; overrides all inputs, including mid-WAIT_RET or HALTED.
REQ-032 First valid fetch SHALL occur at the first posedge with rst_n high.

Structure
REQ-033 y86_pkg holds icode constants (IHALT..IPOPQ), status codes (SAOK=1, SHLT=2, SADR=3, SINS=4), RNONE=4'hF, FSM state enum.
REQ-034 Combinational sub-module y86_inst_split: byte split, length, valC, validity, valP.
REQ-035 fetch_stage holds only PC register, FSM, D register.

Verification
REQ-036 Reset, inst=80'h30F4_0A00_0000_0000_0000 (irmovq $10,%rsp) at pc 0 -> d_icode 3, d_ra F, d_rb 4, d_valc 10, d_valp 10, pc 10, d_stat 1.
REQ-037 inst byte0 8'h70, bytes1..8 = 0x20 LE -> d_valp 9, next pc 0x20.
REQ-038 ret (8'h90) -> one valid ret, then bubbles, pc held; redirect_valid=1, redirect_pc 0x40 -> pc 0x40, RUN.
REQ-039 byte0 8'hC0 -> d_stat 4, HALTED; byte0 8'h00 -> d_stat 2, HALTED; irmovq at pc 0xFFA -> d_stat 3.
REQ-040 stall 3 cycles mid-stream -> pc and D fields constant; stall+redirect same cycle -> redirect taken, bubble.
REQ-041 rst_n low during WAIT_RET -> next cycle pc=RESET_PC, d_valid 0, RUN.
